// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI burst slave: FSM states, opcodes
// and the bit-counter width helper.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_TA,
        S_RD_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Counter must hold values up to the longer of the address and data fields.
    function automatic int spi_cnt_width(input int aw, input int dw);
        return $clog2(((aw > dw) ? aw : dw) + 1);
    endfunction

endpackage

// File: rtl/spi_ram_burst_slave_if.sv
// SPI pin bundle plus status outputs of the burst slave.
interface spi_ram_burst_slave_if;

    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    logic frame_err;

    modport slave (
        input  SS_n,
        input  MOSI,
        output MISO,
        output busy,
        output frame_err
    );

    modport master (
        output SS_n,
        output MOSI,
        input  MISO,
        input  busy,
        input  frame_err
    );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port RAM: synchronous write, asynchronous read, one shared address.
module spi_ram_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // No reset: contents survive rst by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/spi_ram_burst_slave.sv
// SPI slave with integrated RAM: 2-bit opcode frames, auto-incrementing
// burst write/read with address wrap, and abort detection.
module spi_ram_burst_slave
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_ram_burst_slave_if.slave  bus
);

    localparam int CW = spi_cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int SW = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) - 1;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  op_hi;
    logic [SW-1:0]         shift;
    logic [DATA_WIDTH-1:0] tx_reg;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  frame_err_q;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    logic                  last_addr_bit;
    logic                  last_data_bit;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] fold_addr(input logic [ADDR_WIDTH-1:0] a);
        return ADDR_WIDTH'(int'(a) % MEM_DEPTH);
    endfunction

    assign last_addr_bit = (cnt == CW'(ADDR_WIDTH - 1));
    assign last_data_bit = (cnt == CW'(DATA_WIDTH - 1));

    // Only WR_DATA writes; every other state reads through rd_addr.
    assign mem_addr = (state == S_WR_DATA) ? wr_addr : rd_addr;
    assign mem_din  = {shift[DATA_WIDTH-2:0], bus.MOSI};
    assign mem_we   = !rst && !bus.SS_n && (state == S_WR_DATA) && last_data_bit;

    spi_ram_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (mem_din),
        .dout (mem_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_hi       <= 1'b0;
            shift       <= '0;
            tx_reg      <= '0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (bus.SS_n) begin
                state <= S_IDLE;
                cnt   <= '0;
                if (state == S_CMD ||
                    ((state == S_WR_ADDR || state == S_WR_DATA || state == S_RD_ADDR) &&
                     cnt != '0)) begin
                    frame_err_q <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        op_hi <= bus.MOSI;
                        state <= S_CMD;
                    end
                    S_CMD: begin
                        case ({op_hi, bus.MOSI})
                            OP_WR_ADDR: state <= S_WR_ADDR;
                            OP_WR_DATA: state <= S_WR_DATA;
                            OP_RD_ADDR: state <= S_RD_ADDR;
                            OP_RD_DATA: state <= S_RD_TA;
                        endcase
                    end
                    S_WR_ADDR, S_RD_ADDR: begin
                        shift <= {shift[SW-2:0], bus.MOSI};
                        if (last_addr_bit) begin
                            if (state == S_WR_ADDR) begin
                                wr_addr <= fold_addr({shift[ADDR_WIDTH-2:0], bus.MOSI});
                            end else begin
                                rd_addr <= fold_addr({shift[ADDR_WIDTH-2:0], bus.MOSI});
                            end
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WR_DATA: begin
                        shift <= {shift[SW-2:0], bus.MOSI};
                        if (last_data_bit) begin
                            wr_addr <= next_addr(wr_addr);
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RD_TA: begin
                        tx_reg  <= mem_dout;
                        rd_addr <= next_addr(rd_addr);
                        cnt     <= '0;
                        state   <= S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        // Reload on the edge that retires the last bit keeps the stream gapless.
                        if (last_data_bit) begin
                            tx_reg  <= mem_dout;
                            rd_addr <= next_addr(rd_addr);
                            cnt     <= '0;
                        end else begin
                            tx_reg <= tx_reg << 1;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.MISO      = (state == S_RD_DATA) ? tx_reg[DATA_WIDTH-1] : 1'b0;
    assign bus.busy      = (state != S_IDLE);
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Randomised bench for spi_ram_burst_slave: default and 16-bit/16-word builds
// checked against a frame-level memory model.
module tb_spi_ram_burst_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_ram_burst_slave_if bus0 ();
    spi_ram_burst_slave_if bus1 ();

    spi_ram_burst_slave u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    spi_ram_burst_slave #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (16),
        .MEM_DEPTH  (16)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mdl [2][256];
    int          wp [2];
    int          rp [2];
    logic [15:0] wr_buf [$];
    logic [15:0] rd_buf [256];

    function automatic int aw(input int w);    return (w == 0) ? 8 : 4;          endfunction
    function automatic int dw(input int w);    return (w == 0) ? 8 : 16;         endfunction
    function automatic int depth(input int w); return (w == 0) ? 256 : 16;       endfunction
    function automatic logic [15:0] dmask(input int w); return (w == 0) ? 16'h00FF : 16'hFFFF; endfunction

    function automatic logic miso(input int w); return (w == 0) ? bus0.MISO : bus1.MISO;           endfunction
    function automatic logic busy(input int w); return (w == 0) ? bus0.busy : bus1.busy;           endfunction
    function automatic logic ferr(input int w); return (w == 0) ? bus0.frame_err : bus1.frame_err; endfunction
    function automatic logic rbit();            return 1'($urandom_range(1, 0));                   endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive pins while clk is low, return on the following falling edge.
    task automatic cyc(input int w, input logic ss, input logic mosi);
        if (w == 0) begin
            bus0.SS_n = ss;
            bus0.MOSI = mosi;
        end else begin
            bus1.SS_n = ss;
            bus1.MOSI = mosi;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bits(input int w, input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(w, 1'b0, val[i]);
        end
    endtask

    task automatic end_frame(input int w, input logic exp_err);
        cyc(w, 1'b1, rbit());
        check("frame_err", 32'(ferr(w)), 32'(exp_err));
        check("busy_idle", 32'(busy(w)), 0);
        cyc(w, 1'b1, rbit());
        check("frame_err_width", 32'(ferr(w)), 0);
    endtask

    task automatic set_wr_addr(input int w, input int a);
        send_bits(w, 32'd0, 2);
        send_bits(w, 32'(a), aw(w));
        end_frame(w, 1'b0);
        wp[w] = a % depth(w);
    endtask

    task automatic set_rd_addr(input int w, input int a);
        send_bits(w, 32'd2, 2);
        send_bits(w, 32'(a), aw(w));
        end_frame(w, 1'b0);
        rp[w] = a % depth(w);
    endtask

    task automatic write_burst(input int w);
        send_bits(w, 32'd1, 2);
        for (int i = 0; i < wr_buf.size(); i++) begin
            send_bits(w, 32'(wr_buf[i]), dw(w));
            if (i == 0) check("miso_quiet_wr", 32'(miso(w)), 0);
            mdl[w][wp[w]] = wr_buf[i] & dmask(w);
            wp[w] = (wp[w] + 1) % depth(w);
        end
        end_frame(w, 1'b0);
    endtask

    task automatic read_burst(input int w, input int n);
        logic [15:0] word;
        send_bits(w, 32'd3, 2);
        cyc(w, 1'b0, rbit());
        check("busy_rd", 32'(busy(w)), 1);
        for (int j = 0; j < n; j++) begin
            word = '0;
            for (int b = 0; b < dw(w); b++) begin
                if (j != 0 || b != 0) cyc(w, 1'b0, rbit());
                word = {word[14:0], miso(w)};
            end
            rd_buf[j] = word;
            check("rd_word", 32'(word), 32'(mdl[w][rp[w]]));
            rp[w] = (rp[w] + 1) % depth(w);
        end
        end_frame(w, 1'b0);
    endtask

    task automatic fill_random(input int w, input int n);
        wr_buf = {};
        for (int i = 0; i < n; i++) wr_buf.push_back(16'($urandom) & dmask(w));
    endtask

    initial begin
        logic [2:0] top3;
        logic [7:0] exp80;
        int w;
        int a;
        int k;

        bus0.SS_n = 1'b1; bus0.MOSI = 1'b0;
        bus1.SS_n = 1'b1; bus1.MOSI = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_miso", 32'(miso(i)), 0);
            check("rst_busy", 32'(busy(i)), 0);
            check("rst_ferr", 32'(ferr(i)), 0);
            wp[i] = 0;
            rp[i] = 0;
        end

        // Preload both memories completely so the model is fully defined.
        for (int i = 0; i < 2; i++) begin
            set_wr_addr(i, 0);
            fill_random(i, depth(i));
            write_burst(i);
        end

        // Reset with an active frame select and toggling data.
        rst = 1'b1;
        bus0.SS_n = 1'b0; bus1.SS_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus0.MOSI = i[0];
            bus1.MOSI = ~i[0];
            @(posedge clk);
            @(negedge clk);
            check("rst_hold_miso", 32'(bus0.MISO), 0);
            check("rst_hold_busy", 32'(bus0.busy), 0);
            check("rst_hold_ferr", 32'(bus0.frame_err), 0);
            check("rst_hold_busy1", 32'(bus1.busy), 0);
        end
        rst = 1'b0;
        bus0.SS_n = 1'b1; bus1.SS_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            wp[i] = 0;
            rp[i] = 0;
            read_burst(i, depth(i));
        end

        // Burst write across the top of the address space, then continue without a new address.
        set_wr_addr(0, 'hFE);
        wr_buf = {16'hA5, 16'h3C, 16'h81};
        write_burst(0);
        wr_buf = {16'h77};
        write_burst(0);
        set_rd_addr(0, 'hFE);
        read_burst(0, 4);
        check("wrap_fe", 32'(rd_buf[0]), 32'hA5);
        check("wrap_ff", 32'(rd_buf[1]), 32'h3C);
        check("wrap_00", 32'(rd_buf[2]), 32'h81);
        check("wrap_01", 32'(rd_buf[3]), 32'h77);

        // Aborted partial word, opcode and read address.
        set_wr_addr(0, 'h40);
        send_bits(0, 32'd1, 2);
        send_bits(0, 32'h1F, 5);
        end_frame(0, 1'b1);
        send_bits(0, 32'd1, 1);
        end_frame(0, 1'b1);
        send_bits(0, 32'd2, 2);
        send_bits(0, 32'h5, 3);
        end_frame(0, 1'b1);
        wr_buf = {16'h5A};
        write_burst(0);
        set_rd_addr(0, 'h40);
        read_burst(0, 2);
        check("abort_word_lands", 32'(rd_buf[0]), 32'h5A);

        // Reset while the third bit of a read word is on MISO.
        set_rd_addr(0, 'h80);
        exp80 = mdl[0][8'h80][7:0];
        send_bits(0, 32'd3, 2);
        cyc(0, 1'b0, rbit());
        top3[2] = miso(0);
        cyc(0, 1'b0, rbit());
        top3[1] = miso(0);
        cyc(0, 1'b0, rbit());
        top3[0] = miso(0);
        check("midread_bits", 32'(top3), 32'(exp80[7:5]));
        rst = 1'b1;
        cyc(0, 1'b0, rbit());
        rst = 1'b0;
        check("midread_rst_miso", 32'(miso(0)), 0);
        check("midread_rst_busy", 32'(busy(0)), 0);
        for (int i = 0; i < 2; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        cyc(0, 1'b1, 1'b0);
        read_burst(0, 2);
        check("midread_rdaddr0", 32'(rd_buf[0]), 32'h81);

        // Wide build: 17-word burst from 0 wraps onto word 0.
        set_wr_addr(1, 0);
        wr_buf = {};
        for (int i = 0; i <= 16; i++) wr_buf.push_back(16'(i));
        write_burst(1);
        set_rd_addr(1, 0);
        read_burst(1, 16);
        check("wide_mem0", 32'(rd_buf[0]), 32'h0010);
        check("wide_mem1", 32'(rd_buf[1]), 32'h0001);
        check("wide_mem15", 32'(rd_buf[15]), 32'h000F);

        // Random traffic on both builds.
        for (int it = 0; it < 60; it++) begin
            w = int'($urandom_range(1, 0));
            a = int'($urandom_range(depth(w) - 1, 0));
            case ($urandom_range(4, 0))
                0, 1: begin
                    set_wr_addr(w, a);
                    fill_random(w, int'($urandom_range(5, 1)));
                    write_burst(w);
                end
                2, 3: begin
                    set_rd_addr(w, a);
                    read_burst(w, int'($urandom_range(5, 1)));
                end
                default: begin
                    if ($urandom_range(1, 0) == 0) begin
                        k = int'($urandom_range(dw(w) - 1, 1));
                        send_bits(w, 32'd1, 2);
                    end else begin
                        k = int'($urandom_range(aw(w) - 1, 1));
                        send_bits(w, ($urandom_range(1, 0) == 0) ? 32'd0 : 32'd2, 2);
                    end
                    send_bits(w, $urandom, k);
                    end_frame(w, 1'b1);
                end
            endcase
        end

        // Pointers must have survived the aborts untouched.
        for (int i = 0; i < 2; i++) begin
            read_burst(i, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
